c_tt2_mrcs_stim: RTL and testbench



---
 rtl/c_tt2_mrcs_stim_pkg.sv | 32 +++
 rtl/c_tt2_mrcs_stim_phase.sv | 37 +++
 rtl/c_tt2_mrcs_stim.sv | 122 ++++++++++++
 tb/tb_c_tt2_mrcs_stim.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/c_tt2_mrcs_stim_pkg.sv
// rtl/c_tt2_mrcs_stim_pkg.sv - shared state encoding, LFSR constants and pin map
package c_tt2_mrcs_stim_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_DONE
  } state_t;

  // Taps b7/b5/b4/b3; feedback is the parity of shreg & LFSR_TAPS.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  localparam logic [3:0] SEED_LO   = 4'b1010;

  localparam int PIN_CLK   = 0;
  localparam int PIN_RST   = 1;
  localparam int PIN_START = 2;
  localparam int PIN_MODE  = 3;
  localparam int PIN_NIB   = 4;

  localparam int PIN_D          = 0;
  localparam int PIN_EN         = 1;
  localparam int PIN_SCLK       = 2;
  localparam int PIN_BUSY       = 3;
  localparam int PIN_DONE       = 4;
  localparam int PIN_EXP_LATCH  = 5;
  localparam int PIN_EXP_DFF    = 6;
  localparam int PIN_FRAME_MARK = 7;

endpackage

// File: rtl/c_tt2_mrcs_stim_phase.sv
// rtl/c_tt2_mrcs_stim_phase.sv - per-bit cycle counter flagging the last setup/strobe/hold cycle
module c_tt2_mrcs_stim_phase #(
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic setup_last,
  output logic strobe_last,
  output logic hold_last
);

  localparam int PERIOD = SETUP_CYCLES + STROBE_CYCLES + HOLD_CYCLES;
  localparam int CW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  localparam logic [CW-1:0] SETUP_END  = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] STROBE_END = CW'(SETUP_CYCLES + STROBE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_END   = CW'(PERIOD - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= hold_last ? '0 : cnt + 1'b1;
    end
  end

  assign setup_last  = (cnt == SETUP_END);
  assign strobe_last = (cnt == STROBE_END);
  assign hold_last   = (cnt == HOLD_END);

endmodule

// File: rtl/c_tt2_mrcs_stim.sv
// rtl/c_tt2_mrcs_stim.sv - bit-serial latch/flop stimulus transmitter with expected-Q models
module c_tt2_mrcs_stim
  import c_tt2_mrcs_stim_pkg::*;
#(
  parameter int FRAME_BITS    = 8,
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 1
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  localparam int BW = $clog2(FRAME_BITS);
  localparam logic [BW-1:0] BIT_END = BW'(FRAME_BITS - 1);

  if (FRAME_BITS < 2 || FRAME_BITS > 8 || SETUP_CYCLES < 1 ||
      STROBE_CYCLES < 1 || HOLD_CYCLES < 1) begin : g_bad_param
    $error("c_tt2_mrcs_stim: illegal frame or cycle-count parameter");
  end

  logic       clk, rst, start, mode;
  logic [3:0] nib;

  assign clk   = io_in[PIN_CLK];
  assign rst   = io_in[PIN_RST];
  assign start = io_in[PIN_START];
  assign mode  = io_in[PIN_MODE];
  assign nib   = io_in[PIN_NIB +: 4];

  state_t          state, state_n;
  logic [7:0]      shreg, shreg_n;
  logic [BW-1:0]   bit_idx, bit_idx_n;
  logic            mode_q;
  logic            setup_last, strobe_last, hold_last;
  logic            d_q, en_q, busy_q, done_q, exp_latch_q, exp_dff_q, frame_mark_q;
  logic            in_bit;

  c_tt2_mrcs_stim_phase #(
    .SETUP_CYCLES (SETUP_CYCLES),
    .STROBE_CYCLES(STROBE_CYCLES),
    .HOLD_CYCLES  (HOLD_CYCLES)
  ) u_phase (
    .clk        (clk),
    .rst        (rst),
    .clr        (state == ST_LOAD),
    .run        (state == ST_SETUP || state == ST_STROBE || state == ST_HOLD),
    .setup_last (setup_last),
    .strobe_last(strobe_last),
    .hold_last  (hold_last)
  );

  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    bit_idx_n = bit_idx;
    case (state)
      ST_IDLE:   if (start) state_n = ST_LOAD;
      ST_LOAD: begin
        shreg_n   = mode ? {nib, nib} : {nib, SEED_LO};
        bit_idx_n = '0;
        state_n   = ST_SETUP;
      end
      ST_SETUP:  if (setup_last) state_n = ST_STROBE;
      ST_STROBE: if (strobe_last) state_n = ST_HOLD;
      ST_HOLD: begin
        if (hold_last) begin
          shreg_n = {shreg[6:0], mode_q ? 1'b0 : ^(shreg & LFSR_TAPS)};
          if (bit_idx == BIT_END) begin
            state_n = ST_DONE;
          end else begin
            bit_idx_n = bit_idx + 1'b1;
            state_n   = ST_SETUP;
          end
        end
      end
      ST_DONE:   state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  assign in_bit = (state_n == ST_SETUP || state_n == ST_STROBE || state_n == ST_HOLD);

  // Outputs are registered from next-state values so each pin lines up with its state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      shreg        <= '0;
      bit_idx      <= '0;
      mode_q       <= 1'b0;
      d_q          <= 1'b0;
      en_q         <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      exp_latch_q  <= 1'b0;
      exp_dff_q    <= 1'b0;
      frame_mark_q <= 1'b0;
    end else begin
      state   <= state_n;
      shreg   <= shreg_n;
      bit_idx <= bit_idx_n;
      if (state == ST_LOAD) mode_q <= mode;
      if (state_n == ST_SETUP) d_q <= shreg_n[7];
      en_q         <= (state_n == ST_STROBE);
      busy_q       <= in_bit || (state_n == ST_LOAD);
      done_q       <= (state_n == ST_DONE);
      frame_mark_q <= in_bit && (bit_idx_n == '0);
      if (state_n == ST_STROBE) exp_latch_q <= d_q;
      if (state == ST_SETUP && state_n == ST_STROBE) exp_dff_q <= d_q;
    end
  end

  assign io_out[PIN_D]          = d_q;
  assign io_out[PIN_EN]         = en_q;
  assign io_out[PIN_SCLK]       = en_q;
  assign io_out[PIN_BUSY]       = busy_q;
  assign io_out[PIN_DONE]       = done_q;
  assign io_out[PIN_EXP_LATCH]  = exp_latch_q;
  assign io_out[PIN_EXP_DFF]    = exp_dff_q;
  assign io_out[PIN_FRAME_MARK] = frame_mark_q;

endmodule

// File: tb/tb_c_tt2_mrcs_stim.sv
// tb/tb_c_tt2_mrcs_stim.sv - directed and randomized frames checked against a behavioural frame model
module tb_c_tt2_mrcs_stim;

  localparam int S_CYC     = 1;
  localparam int ST_CYC    = 2;
  localparam int H_CYC     = 1;
  localparam int BIT_CYC   = S_CYC + ST_CYC + H_CYC;
  localparam int FRAME_LEN = 1 + 8 * BIT_CYC + 1;

  logic       clk = 1'b0;
  logic       rst, start, mode;
  logic [3:0] nib;
  logic [7:0] io_in;
  logic [7:0] io_out;

  assign io_in = {nib, mode, start, rst, clk};

  c_tt2_mrcs_stim dut (
    .io_in (io_in),
    .io_out(io_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit p_d, p_l, p_f;
  bit bits[8];
  logic [7:0] strobed;

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input int idx, input logic [7:0] obs,
                       input logic [7:0] exp, input logic [7:0] mask);
    checks++;
    assert ((obs & mask) === (exp & mask)) else begin
      errors++;
      $error("FAIL %s[%0d]: observed %08b expected %08b (mask %08b)", tag, idx, obs, exp, mask);
    end
  endtask

  function automatic void gen_bits(input bit m, input logic [3:0] n);
    int v = m ? int'(n) * 17 : int'(n) * 16 + 10;
    int fb;
    for (int i = 0; i < 8; i++) begin
      bits[i] = bit'((v >> 7) & 1);
      fb = ((v >> 7) ^ (v >> 5) ^ (v >> 4) ^ (v >> 3)) & 1;
      v  = ((v << 1) & 255) | (m ? 0 : fb);
    end
  endfunction

  function automatic logic [7:0] model_pattern();
    logic [7:0] r = '0;
    for (int i = 0; i < 8; i++) r = {r[6:0], logic'(bits[i])};
    return r;
  endfunction

  // Expected {frame_mark, exp_dff, exp_latch, done, busy, sclk, en, d} at cycle c (0 = LOAD).
  function automatic logic [7:0] expect_at(input int c);
    bit d, en, busy, done, lat, dff, fm;
    int k, i, ph;
    {d, en, busy, done, lat, dff, fm} = '0;
    if (c == 0) begin
      d = p_d; busy = 1; lat = p_l; dff = p_f;
    end else if (c <= 8 * BIT_CYC) begin
      k = c - 1; i = k / BIT_CYC; ph = k % BIT_CYC;
      d = bits[i]; busy = 1; fm = (i == 0);
      en = (ph >= S_CYC) && (ph < S_CYC + ST_CYC);
      if (ph < S_CYC) begin
        lat = (i == 0) ? p_l : bits[i-1];
        dff = (i == 0) ? p_f : bits[i-1];
      end else begin
        lat = bits[i]; dff = bits[i];
      end
    end else begin
      d = bits[7]; done = 1; lat = bits[7]; dff = bits[7];
    end
    return {fm, dff, lat, done, busy, en, en, d};
  endfunction

  task automatic run_frame(input string tag, input bit m, input logic [3:0] n,
                           input bit keep_start, input int glitch_at, input int rst_at);
    int dones = 0;
    gen_bits(m, n);
    mode = m; nib = n; start = 1'b1; strobed = '0;
    step;
    for (int c = 0; c < FRAME_LEN; c++) begin
      if (c > 0) begin
        start = keep_start || (c == glitch_at);
        rst   = (c == rst_at);
        step;
      end
      if (rst) begin
        check({tag, "_rst"}, c, io_out, 8'h00, 8'hFF);
        rst = 1'b0; start = 1'b0;
        p_d = 0; p_l = 0; p_f = 0;
        return;
      end
      check(tag, c, io_out, expect_at(c), (c == 0) ? 8'hFE : 8'hFF);
      if (io_out[4]) dones++;
      if (c >= 1 && c <= 8 * BIT_CYC && ((c - 1) % BIT_CYC) == S_CYC)
        strobed = {strobed[6:0], io_out[0]};
    end
    p_d = bits[7]; p_l = bits[7]; p_f = bits[7];
    start = keep_start;
    step;
    check({tag, "_idle"}, 0, io_out, 8'h00, 8'b1001_1110);
    checks++;
    assert (dones === 1) else begin
      errors++;
      $error("FAIL %s_done_count: observed %0d expected 1", tag, dones);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; mode = 1'b0; nib = 4'h0;
    p_d = 0; p_l = 0; p_f = 0;
    for (int i = 0; i < 3; i++) begin
      step;
      check("reset", i, io_out, 8'h00, 8'hFF);
    end
    rst = 1'b0; start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step;
      check("idle_after_reset", i, io_out, 8'h00, 8'hFF);
    end

    run_frame("fixed_a", 1'b1, 4'hA, 1'b0, -1, -1);
    check("fixed_a_pattern", 0, strobed, 8'hAA, 8'hFF);

    run_frame("lfsr0_first", 1'b0, 4'h0, 1'b1, -1, -1);
    check("lfsr0_first_pattern", 0, strobed, 8'h0A, 8'hFF);
    run_frame("lfsr0_second", 1'b0, 4'h0, 1'b0, -1, -1);
    check("lfsr0_second_pattern", 0, strobed, 8'h0A, 8'hFF);

    run_frame("glitch_start", 1'b1, 4'h6, 1'b0, 1 + 3 * BIT_CYC + S_CYC, -1);
    check("glitch_pattern", 0, strobed, 8'h66, 8'hFF);
    for (int i = 0; i < 3; i++) begin
      step;
      check("glitch_quiet", i, io_out, 8'h00, 8'b1001_1110);
    end

    run_frame("mid_reset", 1'b0, 4'h5, 1'b0, -1, 1 + 5 * BIT_CYC + S_CYC + ST_CYC + H_CYC);
    step;
    check("mid_reset_idle", 0, io_out, 8'h00, 8'hFF);
    run_frame("after_reset", 1'b0, 4'h5, 1'b0, -1, -1);
    check("after_reset_pattern", 0, strobed, 8'h5A, 8'hFF);

    for (int r = 0; r < 8; r++) begin
      bit m, ks;
      logic [3:0] n;
      m  = bit'($urandom_range(0, 1));
      ks = bit'($urandom_range(0, 1));
      n  = 4'($urandom_range(0, 15));
      run_frame("random", m, n, ks, int'($urandom_range(1, FRAME_LEN - 1)), -1);
      check("random_pattern", r, strobed, model_pattern(), 8'hFF);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
